// File: rtl/regfile_pkg.sv
// Shared types and defaults for the parametrised register file and its
// busy scoreboard.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_REG  = 0;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits. A reservation (set) beats a writeback release
// (clear) on the same register; flush wipes every bit.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS  = NREGS_DEF,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_sel,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_sel,
  input  logic [ADDR_W-1:0] lk_sel_1,
  input  logic [ADDR_W-1:0] lk_sel_2,
  output logic              lk_busy_1,
  output logic              lk_busy_2
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_next;

  // Clear applied before set so a younger reservation survives the release.
  always_comb begin
    w_next = r_busy;
    if (clr_en) w_next[clr_sel] = 1'b0;
    if (set_en) w_next[set_sel] = 1'b1;
    w_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_busy <= '0;
    else if (flush) r_busy <= '0;
    else            r_busy <= w_next;
  end

  assign lk_busy_1 = r_busy[lk_sel_1];
  assign lk_busy_2 = r_busy[lk_sel_2];

endmodule

// File: rtl/regfile_mp.sv
// Register file with sequential clear engine and busy scoreboard.
// Optional write-first bypass on all read ports: define REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int XLEN   = XLEN_DEF,
  parameter  int NREGS  = NREGS_DEF,
  localparam int ADDR_W = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req,
  output logic              ready,
  input  logic [ADDR_W-1:0] r_sel_1,
  input  logic [ADDR_W-1:0] r_sel_2,
  output logic [XLEN-1:0]   r_data_1,
  output logic [XLEN-1:0]   r_data_2,
  output logic              busy_1,
  output logic              busy_2,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] w_sel,
  input  logic [XLEN-1:0]   w_data,
  input  logic              res_en,
  input  logic [ADDR_W-1:0] res_sel,
  input  logic [ADDR_W-1:0] dbg_reg_sel,
  output logic [XLEN-1:0]   dbg_reg_data
);

  localparam logic [ADDR_W-1:0] ZERO_SEL = ADDR_W'(ZERO_REG);
  localparam logic [ADDR_W-1:0] LAST_SEL = ADDR_W'(NREGS - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_ready;
  logic [XLEN-1:0]   r_mem [NREGS];

  logic              w_active;
  logic              w_wr;
  logic              w_res;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [XLEN-1:0]   w_mem_data;
  logic              w_sb_busy_1;
  logic              w_sb_busy_2;
  logic [XLEN-1:0]   w_rd_1;
  logic [XLEN-1:0]   w_rd_2;
  logic [XLEN-1:0]   w_rd_dbg;
  logic              w_busy_1;
  logic              w_busy_2;

  assign w_active = (r_state == READY);
  assign w_wr     = w_active && w_en   && (w_sel   != ZERO_SEL);
  assign w_res    = w_active && res_en && (res_sel != ZERO_SEL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          if (clr_req) begin
            r_clr_cnt <= '0;
          end else if (r_clr_cnt == LAST_SEL) begin
            r_clr_cnt <= '0;
            r_state   <= READY;
            r_ready   <= 1'b1;
          end else begin
            r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
          end
        end
        READY: begin
          if (clr_req) begin
            r_clr_cnt <= '0;
            r_state   <= CLEAR;
            r_ready   <= 1'b0;
          end
        end
        default: begin
          r_state   <= CLEAR;
          r_clr_cnt <= '0;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  // The clear engine shares the single write port so the array needs no reset.
  assign w_mem_we   = !w_active || w_wr;
  assign w_mem_addr = w_active ? w_sel  : r_clr_cnt;
  assign w_mem_data = w_active ? w_data : '0;

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
  end

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .flush     (clr_req),
    .set_en    (w_res),
    .set_sel   (res_sel),
    .clr_en    (w_wr),
    .clr_sel   (w_sel),
    .lk_sel_1  (r_sel_1),
    .lk_sel_2  (r_sel_2),
    .lk_busy_1 (w_sb_busy_1),
    .lk_busy_2 (w_sb_busy_2)
  );

  always_comb begin
    w_rd_1   = (r_sel_1     == ZERO_SEL) ? '0 : r_mem[r_sel_1];
    w_rd_2   = (r_sel_2     == ZERO_SEL) ? '0 : r_mem[r_sel_2];
    w_rd_dbg = (dbg_reg_sel == ZERO_SEL) ? '0 : r_mem[dbg_reg_sel];
    w_busy_1 = w_sb_busy_1;
    w_busy_2 = w_sb_busy_2;
`ifdef REGFILE_BYPASS_EN
    // Write-first: the in-flight write is visible and no longer pending.
    if (w_wr && (w_sel == r_sel_1)) begin
      w_rd_1 = w_data;
      if (!(w_res && (res_sel == r_sel_1))) w_busy_1 = 1'b0;
    end
    if (w_wr && (w_sel == r_sel_2)) begin
      w_rd_2 = w_data;
      if (!(w_res && (res_sel == r_sel_2))) w_busy_2 = 1'b0;
    end
    if (w_wr && (w_sel == dbg_reg_sel)) w_rd_dbg = w_data;
`endif
    if (!w_active) begin
      w_rd_1   = '0;
      w_rd_2   = '0;
      w_rd_dbg = '0;
      w_busy_1 = 1'b0;
      w_busy_2 = 1'b0;
    end
  end

  assign ready        = r_ready;
  assign r_data_1     = w_rd_1;
  assign r_data_2     = w_rd_2;
  assign dbg_reg_data = w_rd_dbg;
  assign busy_1       = w_busy_1;
  assign busy_2       = w_busy_2;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard-checked bench for regfile_mp: stimulus queues expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int ADDR_W = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef enum int {SIG_READY, SIG_RD1, SIG_RD2, SIG_DBG, SIG_BUSY1, SIG_BUSY2} sig_t;

  typedef struct {
    string       name;
    sig_t        sig;
    logic [31:0] exp;
  } expect_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              clr_req;
  logic              ready;
  logic [ADDR_W-1:0] r_sel_1, r_sel_2, w_sel, res_sel, dbg_reg_sel;
  logic [XLEN-1:0]   r_data_1, r_data_2, w_data, dbg_reg_data;
  logic              busy_1, busy_2, w_en, res_en;

  int      nTests = 0;
  int      nFail  = 0;
  expect_t q[$];

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS)) dut (
    .clk          (clk),
    .rst          (rst),
    .clr_req      (clr_req),
    .ready        (ready),
    .r_sel_1      (r_sel_1),
    .r_sel_2      (r_sel_2),
    .r_data_1     (r_data_1),
    .r_data_2     (r_data_2),
    .busy_1       (busy_1),
    .busy_2       (busy_2),
    .w_en         (w_en),
    .w_sel        (w_sel),
    .w_data       (w_data),
    .res_en       (res_en),
    .res_sel      (res_sel),
    .dbg_reg_sel  (dbg_reg_sel),
    .dbg_reg_data (dbg_reg_data)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation mid-cycle, away from the edge.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      expect_t     e;
      logic [31:0] act;
      e = q.pop_front();
      case (e.sig)
        SIG_READY: act = {31'd0, ready};
        SIG_RD1:   act = r_data_1;
        SIG_RD2:   act = r_data_2;
        SIG_DBG:   act = dbg_reg_data;
        SIG_BUSY1: act = {31'd0, busy_1};
        default:   act = {31'd0, busy_2};
      endcase
      nTests++;
      if (act !== e.exp) begin
        nFail++;
        $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", e.name, act, e.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input sig_t sig, input logic [31:0] exp);
    expect_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    q.push_back(e);
  endtask

  task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] ws,
                               input logic [31:0] wd, input logic re,
                               input logic [ADDR_W-1:0] rs);
    w_en    = we;
    w_sel   = ws;
    w_data  = wd;
    res_en  = re;
    res_sel = rs;
  endtask

  task automatic checkClearWindow(input string name);
    for (int c = 0; c < NREGS; c++) begin
      checkOutput({name, "_ready_low"}, SIG_READY, 32'd0);
      checkOutput({name, "_rd1_forced"}, SIG_RD1, 32'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput({name, "_ready_high"}, SIG_READY, 32'd1);
  endtask

  initial begin
    int sels[4] = '{0, 5, 17, 31};
    rst = 1'b1; clr_req = 1'b0;
    r_sel_1 = '0; r_sel_2 = '0; dbg_reg_sel = '0;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    repeat (3) tick();
    r_sel_1 = 5'd5;
    checkOutput("reset_ready", SIG_READY, 32'd0);
    checkOutput("reset_rd1", SIG_RD1, 32'd0);
    tick();

    rst = 1'b0;
    checkClearWindow("init_clear");
    tick();
    foreach (sels[i]) begin
      r_sel_1 = 5'(sels[i]); r_sel_2 = 5'(31 - sels[i]); dbg_reg_sel = 5'(sels[i]);
      checkOutput("post_clear_rd1", SIG_RD1, 32'd0);
      checkOutput("post_clear_rd2", SIG_RD2, 32'd0);
      checkOutput("post_clear_dbg", SIG_DBG, 32'd0);
      tick();
    end

    // Write x5, observe before/after the edge.
    r_sel_1 = 5'd5;
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0);
    checkOutput("x5_same_cycle", SIG_RD1, BYPASS ? 32'hDEADBEEF : 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("x5_next_cycle", SIG_RD1, 32'hDEADBEEF);
    tick();

    // Writes to x0 are dropped.
    r_sel_1 = 5'd0; dbg_reg_sel = 5'd5;
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0);
    checkOutput("x0_same_cycle", SIG_RD1, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("x0_after", SIG_RD1, 32'd0);
    checkOutput("dbg_x5", SIG_DBG, 32'hDEADBEEF);
    tick();

    // Reserve x7, release two cycles later.
    r_sel_1 = 5'd7;
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    checkOutput("busy7_no_fwd", SIG_BUSY1, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("busy7_cyc1", SIG_BUSY1, 32'd1);
    tick();
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
    checkOutput("busy7_cyc2", SIG_BUSY1, BYPASS ? 32'd0 : 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("busy7_released", SIG_BUSY1, 32'd0);
    checkOutput("x7_data", SIG_RD1, 32'h77);
    tick();

    // Same-register set and clear: set wins. Different-register: both apply.
    r_sel_2 = 5'd12;
    applyStimulus(1'b1, 5'd7, 32'h78, 1'b1, 5'd7);
    checkOutput("busy7_setclr_same", SIG_BUSY1, 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 5'd12);
    checkOutput("busy7_set_wins", SIG_BUSY1, 32'd1);
    tick();
    applyStimulus(1'b1, 5'd7, 32'h79, 1'b1, 5'd3);
    checkOutput("busy12_set", SIG_BUSY2, 32'd1);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("busy7_cleared_diff", SIG_BUSY1, 32'd0);
    r_sel_2 = 5'd3;
    checkOutput("busy3_set_diff", SIG_BUSY2, 32'd1);
    tick();

    // x3=0x55, then software clear while x12/x3 are busy.
    r_sel_1 = 5'd3; r_sel_2 = 5'd12;
    applyStimulus(1'b1, 5'd3, 32'h55, 1'b0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("x3_written", SIG_RD1, 32'h55);
    checkOutput("busy12_before_clr", SIG_BUSY2, 32'd1);
    clr_req = 1'b1;
    checkOutput("ready_before_clr", SIG_READY, 32'd1);
    tick();
    clr_req = 1'b0;
    applyStimulus(1'b1, 5'd3, 32'hBAD0BAD0, 1'b1, 5'd4);
    checkClearWindow("sw_clear");
    checkOutput("x3_after_clear", SIG_RD1, 32'd0);
    checkOutput("busy12_after_clear", SIG_BUSY2, 32'd0);
    tick();
    r_sel_1 = 5'd4; r_sel_2 = 5'd3;
    checkOutput("busy4_ignored", SIG_BUSY1, 32'd0);
    checkOutput("busy3_flushed", SIG_BUSY2, 32'd0);
    tick();

    // Reset pulse at clr_cnt=10 restarts the full clear.
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    r_sel_1 = 5'd3;
    applyStimulus(1'b1, 5'd3, 32'hCAFECAFE, 1'b1, 5'd3);
    checkClearWindow("rst_mid_clear");
    checkOutput("x3_after_rst_clear", SIG_RD1, 32'd0);
    tick();
    r_sel_1 = 5'd5;
    checkOutput("x5_after_rst_clear", SIG_RD1, 32'd0);
    tick();

    // Bypass behaviour on read port 2 and the debug port.
    r_sel_2 = 5'd9; dbg_reg_sel = 5'd9;
    applyStimulus(1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0);
    checkOutput("x9_rd2_same", SIG_RD2, BYPASS ? 32'hA5A5A5A5 : 32'd0);
    checkOutput("x9_dbg_same", SIG_DBG, BYPASS ? 32'hA5A5A5A5 : 32'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    checkOutput("x9_rd2_next", SIG_RD2, 32'hA5A5A5A5);
    tick();

    for (int i = 0; i < 10 && q.size() > 0; i++) tick();
    if (q.size() > 0) begin
      nTests++;
      nFail++;
      $display("[TB] FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
